cond_logic: RTL
===============

Name: cond_logic

Overview:
- Conditional-execution stage directly downstream of the instruction decoder in the single-cycle ARM-subset processor.
- Consumes the decoder's PCS, RegW, MemW, FlagW and NoWrite, plus the instruction condition field and the ALU flags.
- Holds the architectural NZCV status flags and evaluates the 4-bit condition code against them.
- Gates the decoder's write strobes into the final PCSrc, RegWrite and MemWrite used by the datapath.

Parameters:
- COND_W, 4, width of the condition field; fixed at 4, exposed for lint only.

Ports:
- Clk  input  1  system clock, rising-edge.
- Reset  input  1  asynchronous, active-high; clears the flag registers.
- En  input  1  flag-register update enable; 0 = stall, hold flags.
- Cond  input  4  instruction bits [31:28].
- ALUFlags  input  4  {N,Z,C,V} from the ALU, current cycle.
- FlagW  input  2  from decoder: [1] = update N,Z; [0] = update C,V.
- PCS  input  1  from decoder: instruction writes the PC.
- RegW  input  1  from decoder: instruction writes the register file.
- MemW  input  1  from decoder: instruction writes memory.
- NoWrite  input  1  from decoder: compare-class op, suppress the register write.
- PCSrc  output  1  PCS & CondEx.
- RegWrite  output  1  RegW & CondEx & ~NoWrite.
- MemWrite  output  1  MemW & CondEx.
- CondEx  output  1  condition passed for the current instruction.
- Flags  output  4  registered {N,Z,C,V}.

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-high; no other reset exists.
- Reset values:
  - Flags = 4'b0000 immediately on Reset assertion, independent of Clk.
  - Outputs follow combinationally from the cleared flags.
  - With Cond = 4'b1110 during reset, CondEx = 1 and the strobes equal the decoder inputs gated by NoWrite.
- Flag storage: two independent registers, NZ = Flags[3:2] and CV = Flags[1:0].
- Flag update, on the rising Clk edge when Reset = 0:
  - NZ <= ALUFlags[3:2] if En & FlagW[1] & CondEx.
  - CV <= ALUFlags[1:0] if En & FlagW[0] & CondEx.
  - Otherwise each register holds its value.
- Condition evaluation is purely combinational from the registered Flags and never from ALUFlags. Zero latency: strobes are valid in the same cycle as the inputs. Flags written by instruction k are visible to instruction k+1.
- CondEx decode by Cond:
  - 0000 EQ: Z. 0001 NE: ~Z.
  - 0010 CS: C. 0011 CC: ~C.
  - 0100 MI: N. 0101 PL: ~N.
  - 0110 VS: V. 0111 VC: ~V.
  - 1000 HI: C & ~Z. 1001 LS: ~C | Z.
  - 1010 GE: N == V. 1011 LT: N != V.
  - 1100 GT: ~Z & (N == V). 1101 LE: Z | (N != V).
  - 1110 AL: 1.
  - 1111: 0 (unsupported encoding, treated as never; no write of any kind).
- Output strobes are purely combinational from the inputs and CondEx; they contain no registers.
- En only affects the flag registers. It does not gate PCSrc, RegWrite or MemWrite; the stall owner gates those upstream.
- Failed condition: all three strobes are 0 and no flag update occurs, even if FlagW != 0.
- NoWrite = 1 with a passing condition: RegWrite = 0, flags update per FlagW, and PCSrc and MemWrite are unaffected.
- Simultaneous FlagW = 2'b11 with a passing condition: both registers update on the same edge.
- Reset asserted mid-cycle: flags clear at once, with no wait for Clk. Release is synchronous-safe: the first update happens on the first rising edge with Reset low.
- No X propagation: every Cond value has a defined CondEx.

Test Plan:
- Reset then hold: assert Reset and drive ALUFlags = 4'b1111, FlagW = 2'b11, En = 1, Cond = 4'b1110 -> Flags stays 4'b0000 throughout reset; on the first edge after release, Flags = 4'b1111.
- Compare then branch: cycle 1 CMP with Cond = 1110, FlagW = 11, NoWrite = 1, RegW = 1, ALUFlags = 0100 -> RegWrite = 0, Flags = 0100 after the edge. Cycle 2 BEQ with Cond = 0000, PCS = 1 -> PCSrc = 1. With Cond = 0001 instead -> PCSrc = 0.
- Failed condition blocks everything: Flags = 0000, Cond = 0000, RegW = MemW = PCS = 1, FlagW = 11, ALUFlags = 1111 -> all strobes 0 and Flags still 0000 after the edge.
- Partial update: Flags = 0000, FlagW = 10, ALUFlags = 1011, Cond = 1110 -> Flags = 1000 after the edge. Then FlagW = 01, ALUFlags = 0111 -> Flags = 1011.
- Stall: En = 0, FlagW = 11, ALUFlags = 1111 for 3 cycles -> Flags unchanged. MemW = 1 with Cond = 1110 still gives MemWrite = 1.
- Exhaustive condition sweep: all 16 Cond values × all 16 registered flag values (loaded via FlagW = 11) -> CondEx matches the decode list above in all 256 cases; Cond = 1111 always gives 0.

Source files
------------

// File: rtl/cond_logic.sv
// cond_logic: conditional-execution stage behind the decoder. It holds the NZCV flags and gates
//   the decoder write strobes by the condition-code result.
// Latency: the strobes are combinational, with zero cycles from the inputs to the outputs. Flags
//   update on the rising Clk edge, so flags written by instruction k are seen by instruction k+1.
// Backpressure: none on the strobes. En=0 stalls only the flag registers; the stall owner gates
//   the strobes upstream.
//
// Ports:
//   Clk, Reset        rising-edge clock; asynchronous active-high reset that clears the flags
//   En                flag-register update enable (0 = hold)
//   Cond              instruction condition field [31:28]
//   ALUFlags          {N,Z,C,V} from the ALU for the current instruction
//   FlagW             [1] = update N,Z; [0] = update C,V
//   PCS/RegW/MemW     raw decoder write strobes
//   NoWrite           compare-class op; suppresses the register write only
//   PCSrc/RegWrite/MemWrite  gated strobes to the datapath
//   CondEx            condition passed for the current instruction
//   Flags             registered {N,Z,C,V}

module cond_logic #(
  parameter int COND_W = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              En,
  input  logic [COND_W-1:0] Cond,
  input  logic [3:0]        ALUFlags,
  input  logic [1:0]        FlagW,
  input  logic              PCS,
  input  logic              RegW,
  input  logic              MemW,
  input  logic              NoWrite,
  output logic              PCSrc,
  output logic              RegWrite,
  output logic              MemWrite,
  output logic              CondEx,
  output logic [3:0]        Flags
);

  // NZ and CV are separate registers so that FlagW can update either half alone.
  logic [1:0] nz_q, nz_d;
  logic [1:0] cv_q, cv_d;

  logic flag_n, flag_z, flag_c, flag_v;
  logic cond_ex;
  logic nz_we, cv_we;

  assign flag_n = nz_q[1];
  assign flag_z = nz_q[0];
  assign flag_c = cv_q[1];
  assign flag_v = cv_q[0];

  // The condition is evaluated only from the registered flags, never from ALUFlags. This keeps
  // the ALU out of the strobe path. Every encoding has a defined result. 4'b1111 is unsupported
  // and is treated as "never".
  always_comb begin
    cond_ex = 1'b0;
    case (Cond)
      4'b0000: cond_ex = flag_z;                          // EQ
      4'b0001: cond_ex = ~flag_z;                         // NE
      4'b0010: cond_ex = flag_c;                          // CS
      4'b0011: cond_ex = ~flag_c;                         // CC
      4'b0100: cond_ex = flag_n;                          // MI
      4'b0101: cond_ex = ~flag_n;                         // PL
      4'b0110: cond_ex = flag_v;                          // VS
      4'b0111: cond_ex = ~flag_v;                         // VC
      4'b1000: cond_ex = flag_c & ~flag_z;                // HI
      4'b1001: cond_ex = ~flag_c | flag_z;                // LS
      4'b1010: cond_ex = (flag_n == flag_v);              // GE
      4'b1011: cond_ex = (flag_n != flag_v);              // LT
      4'b1100: cond_ex = ~flag_z & (flag_n == flag_v);    // GT
      4'b1101: cond_ex = flag_z | (flag_n != flag_v);     // LE
      4'b1110: cond_ex = 1'b1;                            // AL
      default: cond_ex = 1'b0;                            // 1111: never
    endcase
  end

  // A failed condition blocks flag writes as well as the strobes.
  assign nz_we = En & FlagW[1] & cond_ex;
  assign cv_we = En & FlagW[0] & cond_ex;

  always_comb begin
    nz_d = nz_q;
    cv_d = cv_q;
    if (nz_we) nz_d = ALUFlags[3:2];
    if (cv_we) cv_d = ALUFlags[1:0];
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      nz_q <= 2'b00;
      cv_q <= 2'b00;
    end else begin
      nz_q <= nz_d;
      cv_q <= cv_d;
    end
  end

  // En does not gate these strobes; only the flag registers stall.
  assign CondEx   = cond_ex;
  assign PCSrc    = PCS  & cond_ex;
  assign RegWrite = RegW & cond_ex & ~NoWrite;
  assign MemWrite = MemW & cond_ex;
  assign Flags    = {nz_q, cv_q};

endmodule
